bsg_frame_trace_sequencer: RTL and testbench

//  Runs num_nodes_p frame trace-replay nodes one after another. Each node gets a

---
 rtl/bsg_frame_trace_seq_pkg.sv | 22 ++
 rtl/bsg_frame_trace_seq_timer.sv | 34 +++
 rtl/bsg_frame_trace_sequencer.sv | 167 ++++++++++++++++
 tb/tb_bsg_frame_trace_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_frame_trace_seq_pkg.sv
// Shared types and helpers for the frame trace-replay sequencer.
//   bsg_frame_trace_seq_state_e : sequencer FSM states
//   safe_clog2 / max_int        : constant helpers for deriving counter widths
package bsg_frame_trace_seq_pkg;

  typedef enum logic [1:0] {
    eIdle  = 2'd0,
    eReset = 2'd1,
    eRun   = 2'd2,
    eDone  = 2'd3
  } bsg_frame_trace_seq_state_e;

  // clog2 that never returns 0, so a 1-entry range still gets a 1-bit field.
  function automatic int safe_clog2(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_frame_trace_seq_timer.sv
// Clear/up counter with a terminal-match flag. Shared by the sequencer for
// both the per-node reset hold count and the per-node RUN timeout count.
// Ports:
//   clk_i, reset_i : clock, asynchronous active-high reset
//   clear_i        : synchronous clear to 0 (has priority over up_i)
//   up_i           : increment; the count saturates at all-ones
//   limit_i        : terminal value to compare against
//   match_o        : count equals limit_i (decoded from the registered count)
module bsg_frame_trace_seq_timer #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  input  logic [width_p-1:0] limit_i,
  output logic               match_o
);

  logic [width_p-1:0] cnt_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
    end else if (clear_i) begin
      cnt_r <= '0;
    end else if (up_i && (cnt_r != '1)) begin
      cnt_r <= cnt_r + 1'b1;
    end
  end

  assign match_o = (cnt_r == limit_i);

endmodule

// File: rtl/bsg_frame_trace_sequencer.sv
// Sequences num_nodes_p frame trace-replay nodes one after another: each
// node is held in reset for reset_cycles_p cycles, then enabled until it
// reports done or its RUN window times out. Per-node error / timeout status
// is kept in sticky vectors and summarised on error_o.
// Ports:
//   clk_i, reset_i  : clock, asynchronous active-high reset
//   start_i         : start pulse, honoured only in IDLE or DONE
//   node_done_i     : done flags from the nodes (only the current bit is used)
//   node_error_i    : error flags from the nodes (only the current bit is used)
//   node_reset_o    : per-node reset, 1 for every node except the one in RUN
//   node_en_o       : per-node enable, one-hot on the current node in RUN
//   busy_o, done_o  : in RESET/RUN, in DONE
//   error_o         : OR of error_vec_o and timeout_vec_o
//   error_vec_o     : sticky, node raised error during its RUN
//   timeout_vec_o   : sticky, node timed out without done
//   cur_node_o      : index of the node being sequenced
//   state_o         : current FSM state (debug visibility)
module bsg_frame_trace_sequencer
  import bsg_frame_trace_seq_pkg::*;
#(
  parameter int num_nodes_p      = 3,
  parameter int reset_cycles_p   = 4,
  parameter int timeout_cycles_p = 0,
  parameter int stop_on_error_p  = 0,
  localparam int cnt_width_lp    = safe_clog2(max_int(reset_cycles_p, timeout_cycles_p) + 1),
  localparam int idx_width_lp    = safe_clog2(num_nodes_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [num_nodes_p-1:0]  node_done_i,
  input  logic [num_nodes_p-1:0]  node_error_i,
  output logic [num_nodes_p-1:0]  node_reset_o,
  output logic [num_nodes_p-1:0]  node_en_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [num_nodes_p-1:0]  error_vec_o,
  output logic [num_nodes_p-1:0]  timeout_vec_o,
  output logic [idx_width_lp-1:0] cur_node_o,
  output logic [1:0]              state_o
);

  localparam int timeout_limit_int_lp = (timeout_cycles_p == 0) ? 0 : timeout_cycles_p - 1;
  localparam logic [cnt_width_lp-1:0] reset_limit_lp   = cnt_width_lp'(reset_cycles_p - 1);
  localparam logic [cnt_width_lp-1:0] timeout_limit_lp = cnt_width_lp'(timeout_limit_int_lp);
  localparam logic [idx_width_lp-1:0] last_idx_lp      = idx_width_lp'(num_nodes_p - 1);
  localparam logic                    timeout_en_lp    = (timeout_cycles_p != 0);
  localparam logic                    stop_en_lp       = (stop_on_error_p != 0);

  bsg_frame_trace_seq_state_e state_r;
  logic [idx_width_lp-1:0]    idx_r;
  logic [num_nodes_p-1:0]     err_vec_r;
  logic [num_nodes_p-1:0]     to_vec_r;

  logic                       in_reset;
  logic                       in_run;
  logic [num_nodes_p-1:0]     cur_onehot;
  logic                       cur_done;
  logic                       cur_err;
  logic                       tmr_match;
  logic                       tmr_clear;
  logic                       tmr_up;
  logic [cnt_width_lp-1:0]    tmr_limit;
  logic                       to_hit;
  logic                       end_evt;
  logic                       timed_out;
  logic                       node_failed;
  logic                       is_last;

  assign in_reset   = (state_r == eReset);
  assign in_run     = (state_r == eRun);

  // Masking with the one-hot select keeps every other node's done/error out
  // of the decision, and never indexes past the last node.
  assign cur_onehot = num_nodes_p'(1) << idx_r;
  assign cur_done   = |(node_done_i  & cur_onehot);
  assign cur_err    = |(node_error_i & cur_onehot);

  // The timer limit is the last count of the phase, so a match marks the
  // final RESET cycle or the final allowed RUN cycle.
  assign tmr_limit  = in_run ? timeout_limit_lp : reset_limit_lp;
  assign to_hit     = in_run & timeout_en_lp & tmr_match;
  assign end_evt    = in_run & (cur_done | to_hit);
  // Done wins over a timeout landing on the same cycle.
  assign timed_out  = to_hit & ~cur_done;

  // Includes this cycle's error so a node failing on its last RUN cycle
  // still stops the sequence.
  assign node_failed = (|(cur_onehot & (err_vec_r | to_vec_r))) | cur_err | timed_out;
  assign is_last     = (idx_r == last_idx_lp);

  // Counter restarts at every phase boundary and idles at 0 outside RESET/RUN.
  assign tmr_clear = ~(in_reset | in_run) | (in_reset & tmr_match) | end_evt;
  assign tmr_up    = ~tmr_clear;

  bsg_frame_trace_seq_timer #(
    .width_p (cnt_width_lp)
  ) u_timer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (tmr_clear),
    .up_i    (tmr_up),
    .limit_i (tmr_limit),
    .match_o (tmr_match)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= eIdle;
      idx_r     <= '0;
      err_vec_r <= '0;
      to_vec_r  <= '0;
    end else begin
      case (state_r)
        eIdle: begin
          if (start_i) begin
            state_r <= eReset;
            idx_r   <= '0;
          end
        end
        eDone: begin
          if (start_i) begin
            state_r   <= eReset;
            idx_r     <= '0;
            err_vec_r <= '0;
            to_vec_r  <= '0;
          end
        end
        eReset: begin
          if (tmr_match) begin
            state_r <= eRun;
          end
        end
        eRun: begin
          err_vec_r <= err_vec_r | (node_error_i & cur_onehot);
          if (end_evt) begin
            if (timed_out) begin
              to_vec_r <= to_vec_r | cur_onehot;
            end
            if (is_last || (stop_en_lp && node_failed)) begin
              state_r <= eDone;
            end else begin
              state_r <= eReset;
              idx_r   <= idx_r + 1'b1;
            end
          end
        end
        default: begin
          state_r <= eIdle;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state only.
  assign node_en_o     = in_run ? cur_onehot : '0;
  assign node_reset_o  = ~node_en_o;
  assign busy_o        = in_reset | in_run;
  assign done_o        = (state_r == eDone);
  assign error_o       = |(err_vec_r | to_vec_r);
  assign error_vec_o   = err_vec_r;
  assign timeout_vec_o = to_vec_r;
  assign cur_node_o    = idx_r;
  assign state_o       = state_r;

endmodule

// File: tb/tb_bsg_frame_trace_sequencer.sv
// Bench for bsg_frame_trace_sequencer. Three configurations are instantiated
// and exercised one at a time through a select; the reference model builds
// the full expected per-cycle output trace of a sequence from the node plan
// (done / error RUN cycle per node) using plain schedule arithmetic.
module tb_bsg_frame_trace_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- drive variables ----------------
  int         sel;
  logic       drv_start;
  logic [3:0] drv_done;
  logic [3:0] drv_err;

  // configurations: a = N3/r4/to20, b = N4/r3/to8/stop, c = N1/r2/to0
  int cfg_n[3]    = '{3, 4, 1};
  int cfg_rst[3]  = '{4, 3, 2};
  int cfg_to[3]   = '{20, 8, 0};
  int cfg_stop[3] = '{0, 1, 0};

  // ---------------- DUT a ----------------
  logic       a_start;
  logic [2:0] a_done_in, a_err_in, a_nrst, a_en, a_ev, a_tv;
  logic       a_busy, a_done, a_err;
  logic [1:0] a_cur, a_state;
  assign a_start   = (sel == 0) && drv_start;
  assign a_done_in = (sel == 0) ? drv_done[2:0] : 3'b0;
  assign a_err_in  = (sel == 0) ? drv_err[2:0]  : 3'b0;

  bsg_frame_trace_sequencer #(
    .num_nodes_p(3), .reset_cycles_p(4), .timeout_cycles_p(20), .stop_on_error_p(0)
  ) u_dut_a (
    .clk_i(clk), .reset_i(rst), .start_i(a_start),
    .node_done_i(a_done_in), .node_error_i(a_err_in),
    .node_reset_o(a_nrst), .node_en_o(a_en), .busy_o(a_busy), .done_o(a_done),
    .error_o(a_err), .error_vec_o(a_ev), .timeout_vec_o(a_tv),
    .cur_node_o(a_cur), .state_o(a_state)
  );

  // ---------------- DUT b ----------------
  logic       b_start;
  logic [3:0] b_done_in, b_err_in, b_nrst, b_en, b_ev, b_tv;
  logic       b_busy, b_done, b_err;
  logic [1:0] b_cur, b_state;
  assign b_start   = (sel == 1) && drv_start;
  assign b_done_in = (sel == 1) ? drv_done : 4'b0;
  assign b_err_in  = (sel == 1) ? drv_err  : 4'b0;

  bsg_frame_trace_sequencer #(
    .num_nodes_p(4), .reset_cycles_p(3), .timeout_cycles_p(8), .stop_on_error_p(1)
  ) u_dut_b (
    .clk_i(clk), .reset_i(rst), .start_i(b_start),
    .node_done_i(b_done_in), .node_error_i(b_err_in),
    .node_reset_o(b_nrst), .node_en_o(b_en), .busy_o(b_busy), .done_o(b_done),
    .error_o(b_err), .error_vec_o(b_ev), .timeout_vec_o(b_tv),
    .cur_node_o(b_cur), .state_o(b_state)
  );

  // ---------------- DUT c ----------------
  logic       c_start;
  logic [0:0] c_done_in, c_err_in, c_nrst, c_en, c_ev, c_tv, c_cur;
  logic       c_busy, c_done, c_err;
  logic [1:0] c_state;
  assign c_start   = (sel == 2) && drv_start;
  assign c_done_in = (sel == 2) ? drv_done[0:0] : 1'b0;
  assign c_err_in  = (sel == 2) ? drv_err[0:0]  : 1'b0;

  bsg_frame_trace_sequencer #(
    .num_nodes_p(1), .reset_cycles_p(2), .timeout_cycles_p(0), .stop_on_error_p(0)
  ) u_dut_c (
    .clk_i(clk), .reset_i(rst), .start_i(c_start),
    .node_done_i(c_done_in), .node_error_i(c_err_in),
    .node_reset_o(c_nrst), .node_en_o(c_en), .busy_o(c_busy), .done_o(c_done),
    .error_o(c_err), .error_vec_o(c_ev), .timeout_vec_o(c_tv),
    .cur_node_o(c_cur), .state_o(c_state)
  );

  // ---------------- observation word ----------------
  // [20:17] timeout_vec [16:13] error_vec [12] busy [11] done [10] error
  // [9:6] en [5:2] node_reset [1:0] cur_node
  function automatic logic [31:0] pk(input logic [3:0] tv, input logic [3:0] ev,
                                     input logic busy, input logic dn, input logic er,
                                     input logic [3:0] en, input logic [3:0] nr,
                                     input logic [1:0] cur);
    return {11'b0, tv, ev, busy, dn, er, en, nr, cur};
  endfunction

  logic [31:0] obs;
  always_comb begin
    obs = '0;
    case (sel)
      0: obs = pk({1'b0, a_tv}, {1'b0, a_ev}, a_busy, a_done, a_err,
                  {1'b0, a_en}, {1'b0, a_nrst}, a_cur);
      1: obs = pk(b_tv, b_ev, b_busy, b_done, b_err, b_en, b_nrst, b_cur);
      default: obs = pk({3'b0, c_tv}, {3'b0, c_ev}, c_busy, c_done, c_err,
                        {3'b0, c_en}, {3'b0, c_nrst}, {1'b0, c_cur});
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (cfg %0d, t=%0t): got %h expected %h", tag, sel, $time, got, exp);
  endtask

  function automatic logic [3:0] node_mask(input int n);
    logic [4:0] m;
    m = (5'd1 << n) - 5'd1;
    return m[3:0];
  endfunction

  function automatic logic [31:0] idle_word(input int n);
    return pk(4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 4'b0, node_mask(n), 2'b0);
  endfunction

  // Node plan: RUN cycle (1-based) on which node k raises done / error; 0 = never.
  int done_at[4];
  int err_at[4];
  int rc[4];

  task automatic set_plan(input int d0, input int d1, input int d2, input int d3,
                          input int e0, input int e1, input int e2, input int e3);
    done_at = '{d0, d1, d2, d3};
    err_at  = '{e0, e1, e2, e3};
  endtask

  // Reference model: expected trace from the first RESET cycle through DONE.
  task automatic build_trace(input int s);
    int n, r, to, len, k, last;
    bit stop, timed;
    logic [3:0] msk, ev, tv, one;
    n = cfg_n[s]; r = cfg_rst[s]; to = cfg_to[s]; stop = (cfg_stop[s] != 0);
    msk = node_mask(n);
    ev = '0; tv = '0; last = 0;
    exp_q.delete();
    for (k = 0; k < n; k++) begin
      one = 4'b0001 << k;
      for (int c = 0; c < r; c++)
        exp_q.push_back(pk(tv, ev, 1'b1, 1'b0, |(ev | tv), 4'b0, msk, 2'(k)));
      if (done_at[k] != 0 && (to == 0 || done_at[k] <= to)) begin
        len = done_at[k]; timed = 0;
      end else begin
        len = to; timed = 1;
      end
      for (int c = 1; c <= len; c++) begin
        exp_q.push_back(pk(tv, ev, 1'b1, 1'b0, |(ev | tv), one, msk & ~one, 2'(k)));
        if (err_at[k] == c) ev = ev | one;
      end
      if (timed) tv = tv | one;
      last = k;
      if (k == n - 1 || (stop && ((ev & one) != 0 || (tv & one) != 0))) break;
    end
    for (int c = 0; c < 3; c++)
      exp_q.push_back(pk(tv, ev, 1'b0, 1'b1, |(ev | tv), 4'b0, msk, 2'(last)));
  endtask

  // Node behaviour for the current cycle, applied at the negedge: enabled
  // nodes follow the plan, idle nodes show random noise that must be ignored.
  // A start is also thrown at the DUT now and then while it is busy.
  task automatic env_step();
    logic [3:0] en;
    en = obs[9:6];
    for (int k = 0; k < 4; k++) begin
      if (en[k]) begin
        rc[k]++;
        drv_done[k] = (rc[k] == done_at[k]);
        drv_err[k]  = (rc[k] == err_at[k]);
      end else begin
        rc[k] = 0;
        drv_done[k] = 1'($urandom_range(0, 1));
        drv_err[k]  = 1'($urandom_range(0, 1));
      end
    end
    drv_start = obs[12] && ($urandom_range(0, 2) == 0);
  endtask

  task automatic run_case(input int s, input string tag);
    sel = s;
    build_trace(s);
    @(negedge clk);
    rc = '{0, 0, 0, 0};
    drv_done = '0; drv_err = '0;
    drv_start = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      drv_start = 1'b0;
      check_eq(tag, obs, exp_q.pop_front());
      env_step();
    end
    drv_start = 1'b0;
  endtask

  task automatic random_plan(input int s);
    int to;
    to = cfg_to[s];
    for (int k = 0; k < 4; k++) begin
      done_at[k] = (to != 0) ? $urandom_range(0, to + 3) : $urandom_range(1, 12);
      err_at[k]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
    end
  endtask

  // ---------------- main ----------------
  initial begin
    bit found;
    rst = 1'b1; sel = 0;
    drv_start = 1'b0; drv_done = '0; drv_err = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check_eq("reset_state", obs, idle_word(cfg_n[s]));
    end
    @(negedge clk);
    rst = 1'b0;
    sel = 0;
    @(negedge clk);
    check_eq("idle_after_reset", obs, idle_word(3));

    // all nodes finish after 10 RUN cycles: DONE 43 cycles after start
    set_plan(10, 10, 10, 0, 0, 0, 0, 0);
    run_case(0, "seq_basic");
    // node1 never finishes and times out; node2 still runs
    set_plan(10, 0, 10, 0, 0, 0, 0, 0);
    run_case(0, "seq_timeout");
    // node1 errors on RUN cycle 3 and finishes on 8: stop after node1
    set_plan(5, 8, 5, 5, 0, 3, 0, 0);
    run_case(1, "seq_stop_err");
    // done on the same cycle as the timeout: no timeout recorded
    set_plan(8, 8, 8, 8, 0, 0, 0, 0);
    run_case(1, "seq_done_vs_to");
    // single node, done on the first RUN cycle
    set_plan(1, 0, 0, 0, 0, 0, 0, 0);
    run_case(2, "seq_single");

    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 5; i++) begin
        random_plan(s);
        run_case(s, "seq_random");
      end
    end

    // leave config a in DONE with a timeout recorded, then restart from DONE
    set_plan(0, 4, 4, 0, 2, 0, 0, 0);
    run_case(0, "seq_err_then");
    set_plan(6, 6, 6, 0, 0, 0, 0, 0);
    run_case(0, "seq_restart_clears");

    // asynchronous reset in the middle of node1's RUN
    sel = 0;
    set_plan(10, 10, 10, 0, 3, 0, 0, 0);
    @(negedge clk);
    rc = '{0, 0, 0, 0};
    drv_start = 1'b1;
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      drv_start = 1'b0;
      env_step();
      if (obs[1:0] == 2'd1 && obs[7] && rc[1] >= 3) found = 1;
    end
    check_eq("reach_node1_run", 32'(found), 32'd1);
    check_eq("pre_reset_errvec", 32'(obs[16:13]), 32'h1);
    #2 rst = 1'b1;
    drv_start = 1'b1;
    #1 check_eq("async_reset", obs, idle_word(3));
    @(negedge clk);
    rst = 1'b0;
    drv_start = 1'b0;
    @(negedge clk);
    check_eq("idle_after_async", obs, idle_word(3));
    set_plan(3, 3, 3, 0, 0, 0, 0, 0);
    run_case(0, "seq_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
